// File: rtl/fir_out_buffer_if.sv
// Handshake bundle between the FIR output buffer and its neighbours.
// FIR_OBUF_OVFCNT_EN adds the ovfCnt dropped-sample counter output.
interface fir_out_buffer_if #(
  parameter int Nb    = 9,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [Nb-1:0] din;
  logic          vin;
  logic          rdy;
  logic [Nb-1:0] dout;
  logic          vout;
  logic [CW-1:0] count;
  logic          full;
  logic          ovf;
`ifdef FIR_OBUF_OVFCNT_EN
  logic [7:0]    ovfCnt;
`endif

  modport slave (
    input  din, vin, rdy,
    output dout, vout, count, full,
`ifdef FIR_OBUF_OVFCNT_EN
    output ovf, ovfCnt
`else
    output ovf
`endif
  );

  modport master (
    output din, vin, rdy,
    input  dout, vout, count, full,
`ifdef FIR_OBUF_OVFCNT_EN
    input  ovf, ovfCnt
`else
    input  ovf
`endif
  );
endinterface

// File: rtl/fir_out_buffer.sv
// First-word-fall-through FIFO buffering FIR filter output samples.
// Optional macro FIR_OBUF_OVFCNT_EN adds a saturating 8-bit dropped-sample counter.
module fir_out_buffer #(
  parameter int Nb    = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fir_out_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [Nb-1:0] mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rdEn, wrEn, drop;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  always_comb begin
    rdEn    = (count_q != '0) && bus.rdy;
    wrEn    = bus.vin && ((count_q != FullCount) || rdEn);
    drop    = bus.vin && !wrEn;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q | drop;
    if (rdEn) rdPtr_d = rdPtr_q + AW'(1);
    if (wrEn) wrPtr_d = wrPtr_q + AW'(1);
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: only written entries are ever presented on dout.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem_q[wrPtr_q] <= bus.din;
  end

`ifdef FIR_OBUF_OVFCNT_EN
  logic [7:0] ovfCnt_q, ovfCnt_d;

  always_comb begin
    ovfCnt_d = ovfCnt_q;
    if (drop && (ovfCnt_q != 8'hFF)) ovfCnt_d = ovfCnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovfCnt_q <= '0;
    else         ovfCnt_q <= ovfCnt_d;
  end

  assign bus.ovfCnt = ovfCnt_q;
`endif

  // dout is forced to zero while empty so it is never X and clears with reset.
  assign bus.vout  = (count_q != '0);
  assign bus.dout  = bus.vout ? mem_q[rdPtr_q] : '0;
  assign bus.count = count_q;
  assign bus.full  = (count_q == FullCount);
  assign bus.ovf   = ovf_q;
endmodule
